lenet_stream_loader: RTL and testbench
======================================

Name: lenet_stream_loader

Overview:
- Host-side feeder for the LeNet-5 accelerator core; it is the transmitter end of the core's weight, bias and fmap load streams.
- Accepts 32-bit words from the AXI4-Lite register bank over a valid/ready push interface.
- Sequences them into the core's weight, bias and fmap write strobes in the fixed order the core expects, and drives the core's ce.
- Captures the classification result and reports done, busy and timeout status back to the register bank.

Parameters:
- W_BW, 8: weight width; word bits [W_BW-1:0].
- B_BW, 16: FC bias width; word bits [B_BW-1:0].
- I_BW, 8: input fmap pixel width; word bits [I_BW-1:0].
- N_WEIGHT, 3220: weight words per full load (conv1 + conv2 + fc).
- N_BIAS, 10: FC bias words.
- N_FMAP, 784: pixels per image (28x28).
- TIMEOUT, 65535: maximum cycles in WAIT_RES before the error flag.

Ports:
- clk  in  1  clock
- global_rst  in  1  asynchronous active-high reset
- user_reset  in  1  synchronous clear; returns FSM to IDLE and clears status; also forwarded to the core by the top
- i_start  in  1  one-cycle pulse; begins a run
- i_fmap_only  in  1  sampled at start; 1 skips the WEIGHT and BIAS phases (core buffers already full)
- i_wr_valid  in  1  host word valid
- o_wr_ready  out  1  loader accepts a word this cycle
- i_wr_data  in  32  host word
- o_ce  out  1  core clock enable
- o_weight  out  W_BW  weight to the core
- o_weight_buffer_we  out  1  weight write strobe
- o_bias_fc  out  B_BW  bias to the core
- o_bias_buffer_we  out  1  bias write strobe
- o_fmap  out  I_BW  pixel to the core
- o_fmap_buffer_we  out  1  fmap write strobe
- i_classification_result  in  4  class index from the core
- i_classification_en  in  1  result valid
- i_classification_end  in  1  inference complete
- o_result  out  4  captured class
- o_busy  out  1  FSM is not in IDLE or DONE
- o_done  out  1  sticky; result valid
- o_timeout  out  1  sticky; WAIT_RES expired
- o_phase  out  3  state encoding (IDLE=0, WEIGHT=1, BIAS=2, FMAP=3, WAIT_RES=4, DONE=5)

Behaviour:
- Reset values (global_rst asynchronously, user_reset synchronously):
  - FSM = IDLE.
  - All outputs 0, including all data outputs and all strobes.
  - Word counter = 0; timeout counter = 0.
- IDLE:
  - o_wr_ready = 0, o_ce = 0.
  - i_start moves to WEIGHT, or to FMAP if i_fmap_only = 1.
  - On start, o_done and o_timeout are cleared.
- WEIGHT, BIAS and FMAP:
  - o_wr_ready = 1 combinationally from state.
  - A transfer occurs on i_wr_valid & o_wr_ready.
  - On a transfer, the sliced low bits are registered onto the phase's data port and its we is pulsed for exactly one cycle, the cycle after the transfer (latency 1).
  - The we strobes of the other phases stay 0 and are mutually exclusive.
  - Data outputs hold their last value when we = 0.
  - Upper unused word bits are ignored; values are signed two's complement and truncated, never saturated.
- Phase counting:
  - The word counter increments per transfer.
  - On the transfer with count = N-1, the counter clears and the FSM advances the same cycle: WEIGHT->BIAS->FMAP->WAIT_RES.
  - Back-to-back valid therefore gives 1 word per cycle with no bubble across phase boundaries.
- o_ce:
  - 1 from the first cycle after leaving IDLE until entry to DONE.
  - The core's own bias and conv gating handles ordering.
- WAIT_RES:
  - o_wr_ready = 0.
  - i_classification_en captures i_classification_result into o_result; the last capture wins.
  - i_classification_end moves to DONE and sets o_done the next cycle.
  - If en and end arrive in the same cycle, the result is captured and DONE is entered.
  - The timeout counter increments each cycle. At TIMEOUT it sets o_timeout and enters DONE with o_done = 0.
- DONE:
  - o_ce = 0, o_busy = 0.
  - i_start is handled as in IDLE.
- i_start while busy is ignored.
- Classification inputs outside WAIT_RES are ignored.
- user_reset asserted mid-phase aborts the run:
  - any pending strobe is dropped the next cycle;
  - no partial-word effects.
- Words presented while ready = 0 are not consumed; the host holds valid.

Test Plan:
- Full run:
  - Stimulus: start with i_fmap_only = 0; stream 3220 + 10 + 784 words continuously; core model asserts en with result 7, then end.
  - Required response: exactly 3220 weight, 10 bias and 784 fmap we pulses, each one cycle after its transfer; o_result = 7; o_done = 1; o_busy = 0.
- Slicing:
  - Stimulus: weight word 0xFFFF_FF85, bias word 0x0001_8001, pixel word 0x0000_017F.
  - Required response: o_weight = 0x85, o_bias_fc = 0x8001, o_fmap = 0x7F.
- Fmap-only run with gaps:
  - Stimulus: i_fmap_only = 1; valid toggles every other cycle.
  - Required response: o_phase goes 3 then 4; no weight or bias strobes; 784 fmap strobes, each with no extra latency.
- Timeout:
  - Stimulus: TIMEOUT = 100; core never asserts end.
  - Required response: o_timeout = 1 after 100 WAIT_RES cycles; o_done = 0; FSM in DONE; a new start clears o_timeout.
- Abort:
  - Stimulus: user_reset at bias word 5, in the same cycle as a transfer.
  - Required response: no bias strobe follows; FSM IDLE; counters 0; o_ce = 0.
  - Stimulus: global_rst asserted mid-FMAP.
  - Required response: all outputs go to 0 asynchronously.
- Ignored inputs:
  - Stimulus: i_start pulsed in FMAP; classification_en pulsed in BIAS.
  - Required response: state and o_result unchanged.

Source files
------------

// File: rtl/lenet_stream_loader.sv
// lenet_stream_loader
//   Host-side feeder for the LeNet-5 accelerator core. Takes 32-bit words from
//   the register bank over a valid/ready push interface and replays them onto
//   the core's weight, bias and fmap write strobes in load order, drives the
//   core clock enable, then waits for the classification result.
//
// Ports
//   clk, global_rst            clock, asynchronous active-high reset
//   user_reset                 synchronous clear (abort run, clear status)
//   i_start, i_fmap_only       run start pulse; fmap-only selects skip of weight/bias
//   i_wr_valid/o_wr_ready      host word handshake, i_wr_data is the word
//   o_ce                       core clock enable
//   o_weight/_buffer_we        weight data + strobe (W_BW)
//   o_bias_fc/o_bias_buffer_we bias data + strobe (B_BW)
//   o_fmap/_buffer_we          pixel data + strobe (I_BW)
//   i_classification_*         result, result valid, inference complete
//   o_result, o_busy, o_done, o_timeout, o_phase   status to the register bank
//
// State table
//   IDLE     | no run; waiting for i_start
//   WEIGHT   | forwarding N_WEIGHT words to the weight buffer
//   BIAS     | forwarding N_BIAS words to the bias buffer
//   FMAP     | forwarding N_FMAP words to the fmap buffer
//   WAIT_RES | core running; capture result, watch for end or timeout
//   DONE     | run finished (o_done or o_timeout tells which); i_start restarts

module lenet_stream_loader #(
  parameter int W_BW     = 8,
  parameter int B_BW     = 16,
  parameter int I_BW     = 8,
  parameter int N_WEIGHT = 3220,
  parameter int N_BIAS   = 10,
  parameter int N_FMAP   = 784,
  parameter int TIMEOUT  = 65535
) (
  input  logic            clk,
  input  logic            global_rst,
  input  logic            user_reset,
  input  logic            i_start,
  input  logic            i_fmap_only,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [31:0]     i_wr_data,
  output logic            o_ce,
  output logic [W_BW-1:0] o_weight,
  output logic            o_weight_buffer_we,
  output logic [B_BW-1:0] o_bias_fc,
  output logic            o_bias_buffer_we,
  output logic [I_BW-1:0] o_fmap,
  output logic            o_fmap_buffer_we,
  input  logic [3:0]      i_classification_result,
  input  logic            i_classification_en,
  input  logic            i_classification_end,
  output logic [3:0]      o_result,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_timeout,
  output logic [2:0]      o_phase
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WEIGHT   = 3'd1,
    BIAS     = 3'd2,
    FMAP     = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(N_WEIGHT + N_BIAS + N_FMAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_WEIGHT = CNT_W'(N_WEIGHT - 1);
  localparam logic [CNT_W-1:0] LAST_BIAS   = CNT_W'(N_BIAS - 1);
  localparam logic [CNT_W-1:0] LAST_FMAP   = CNT_W'(N_FMAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             xfer;
  logic             last_word;
  logic             start_ok;

  // Only the low slice of each word is meaningful; the rest is discarded.
  logic unused_data_bits;
  assign unused_data_bits = ^i_wr_data;

  assign o_wr_ready = (state == WEIGHT) || (state == BIAS) || (state == FMAP);
  assign o_ce       = o_wr_ready || (state == WAIT_RES);
  assign o_busy     = o_ce;
  assign o_phase    = state;
  assign xfer       = i_wr_valid && o_wr_ready;
  assign start_ok   = i_start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last_word = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_start) state_nxt = i_fmap_only ? FMAP : WEIGHT;
      end
      WEIGHT: begin
        last_word = (word_cnt == LAST_WEIGHT);
        if (xfer && last_word) state_nxt = BIAS;
      end
      BIAS: begin
        last_word = (word_cnt == LAST_BIAS);
        if (xfer && last_word) state_nxt = FMAP;
      end
      FMAP: begin
        last_word = (word_cnt == LAST_FMAP);
        if (xfer && last_word) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (i_classification_end || (tmo_cnt == TMO_LAST)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (user_reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      word_cnt           <= '0;
      tmo_cnt            <= '0;
      o_weight           <= '0;
      o_weight_buffer_we <= 1'b0;
      o_bias_fc          <= '0;
      o_bias_buffer_we   <= 1'b0;
      o_fmap             <= '0;
      o_fmap_buffer_we   <= 1'b0;
      o_result           <= '0;
      o_done             <= 1'b0;
      o_timeout          <= 1'b0;
    end else if (user_reset) begin
      // A word accepted in this same cycle is dropped along with the run.
      word_cnt           <= '0;
      tmo_cnt            <= '0;
      o_weight           <= '0;
      o_weight_buffer_we <= 1'b0;
      o_bias_fc          <= '0;
      o_bias_buffer_we   <= 1'b0;
      o_fmap             <= '0;
      o_fmap_buffer_we   <= 1'b0;
      o_result           <= '0;
      o_done             <= 1'b0;
      o_timeout          <= 1'b0;
    end else begin
      o_weight_buffer_we <= 1'b0;
      o_bias_buffer_we   <= 1'b0;
      o_fmap_buffer_we   <= 1'b0;

      if (xfer) begin
        word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
        case (state)
          WEIGHT: begin
            o_weight           <= i_wr_data[W_BW-1:0];
            o_weight_buffer_we <= 1'b1;
          end
          BIAS: begin
            o_bias_fc        <= i_wr_data[B_BW-1:0];
            o_bias_buffer_we <= 1'b1;
          end
          FMAP: begin
            o_fmap           <= i_wr_data[I_BW-1:0];
            o_fmap_buffer_we <= 1'b1;
          end
          default: ;
        endcase
      end

      if (start_ok) begin
        o_done    <= 1'b0;
        o_timeout <= 1'b0;
        word_cnt  <= '0;
        tmo_cnt   <= '0;
      end

      if (state == WAIT_RES) begin
        if (i_classification_en) o_result <= i_classification_result;
        // End has priority over an expiring timer in the same cycle.
        if (i_classification_end) begin
          o_done  <= 1'b1;
          tmo_cnt <= '0;
        end else if (tmo_cnt == TMO_LAST) begin
          o_timeout <= 1'b1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lenet_stream_loader.sv
// Testbench for lenet_stream_loader: random word streams checked against a
// word-index based reference model of the load order, slicing and status.

module tb_lenet_stream_loader;

  localparam int W_BW     = 8;
  localparam int B_BW     = 16;
  localparam int I_BW     = 8;
  localparam int N_WEIGHT = 3220;
  localparam int N_BIAS   = 10;
  localparam int N_FMAP   = 784;
  localparam int TIMEOUT  = 100;
  localparam int TOTAL    = N_WEIGHT + N_BIAS + N_FMAP;

  logic            clk = 1'b0;
  logic            global_rst;
  logic            user_reset;
  logic            i_start;
  logic            i_fmap_only;
  logic            i_wr_valid;
  logic            o_wr_ready;
  logic [31:0]     i_wr_data;
  logic            o_ce;
  logic [W_BW-1:0] o_weight;
  logic            o_weight_buffer_we;
  logic [B_BW-1:0] o_bias_fc;
  logic            o_bias_buffer_we;
  logic [I_BW-1:0] o_fmap;
  logic            o_fmap_buffer_we;
  logic [3:0]      i_classification_result;
  logic            i_classification_en;
  logic            i_classification_end;
  logic [3:0]      o_result;
  logic            o_busy;
  logic            o_done;
  logic            o_timeout;
  logic [2:0]      o_phase;

  always #5 clk = ~clk;

  lenet_stream_loader #(
    .W_BW(W_BW), .B_BW(B_BW), .I_BW(I_BW),
    .N_WEIGHT(N_WEIGHT), .N_BIAS(N_BIAS), .N_FMAP(N_FMAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .global_rst(global_rst),
    .user_reset(user_reset),
    .i_start(i_start),
    .i_fmap_only(i_fmap_only),
    .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready),
    .i_wr_data(i_wr_data),
    .o_ce(o_ce),
    .o_weight(o_weight),
    .o_weight_buffer_we(o_weight_buffer_we),
    .o_bias_fc(o_bias_fc),
    .o_bias_buffer_we(o_bias_buffer_we),
    .o_fmap(o_fmap),
    .o_fmap_buffer_we(o_fmap_buffer_we),
    .i_classification_result(i_classification_result),
    .i_classification_en(i_classification_en),
    .i_classification_end(i_classification_end),
    .o_result(o_result),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_timeout(o_timeout),
    .o_phase(o_phase)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int         m_idx;
  logic [7:0] m_w;
  logic [15:0] m_b;
  logic [7:0] m_f;
  logic [3:0] m_res;
  int         cnt_w, cnt_b, cnt_f;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // phase the loader should be in once idx words of the full sequence are in
  function automatic logic [2:0] phase_of(input int idx);
    if (idx < N_WEIGHT)          return 3'd1;
    if (idx < N_WEIGHT + N_BIAS) return 3'd2;
    if (idx < TOTAL)             return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_clear;
    m_idx = 0;
    m_w   = '0;
    m_b   = '0;
    m_f   = '0;
    m_res = '0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk_eq({tag, "_ctl"}, 32'({o_wr_ready, o_ce, o_weight_buffer_we, o_bias_buffer_we,
           o_fmap_buffer_we, o_busy, o_done, o_timeout, o_phase}), 32'd0);
    chk_eq({tag, "_data"}, 32'({o_weight, o_bias_fc, o_fmap}), 32'd0);
    chk_eq({tag, "_result"}, 32'(o_result), 32'd0);
  endtask

  task automatic start_run(input logic fo);
    i_fmap_only = fo;
    i_start     = 1'b1;
    tick;
    i_start     = 1'b0;
    i_fmap_only = 1'b0;
    m_idx = fo ? (N_WEIGHT + N_BIAS) : 0;
    cnt_w = 0;
    cnt_b = 0;
    cnt_f = 0;
    chk_eq("start_phase", 32'(o_phase), 32'(phase_of(m_idx)));
    chk_eq("start_status", 32'({o_ce, o_busy, o_done, o_timeout}), 32'(4'b1100));
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random
  task automatic stream(input int mode, input int stop);
    int          cyc;
    logic        v;
    logic [31:0] d;
    logic [2:0]  ph;
    logic [2:0]  exp_we;
    cyc = 0;
    while (m_idx < stop && cyc < 20000) begin
      ph = phase_of(m_idx);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (m_idx == 0)                      d = 32'hFFFF_FF85;
      else if (m_idx == N_WEIGHT)          d = 32'h0001_8001;
      else if (m_idx == N_WEIGHT + N_BIAS) d = 32'h0000_017F;
      if (m_idx == N_WEIGHT + 2) begin
        i_classification_en     = 1'b1;
        i_classification_result = 4'($urandom);
      end
      if (m_idx == N_WEIGHT + N_BIAS + 100) begin
        i_start     = 1'b1;
        i_fmap_only = 1'b1;
      end
      i_wr_valid = v;
      i_wr_data  = d;
      chk_eq("wr_ready", 32'(o_wr_ready), 32'd1);
      tick;
      i_classification_en = 1'b0;
      i_start             = 1'b0;
      i_fmap_only         = 1'b0;
      exp_we = 3'b000;
      if (v) begin
        if (ph == 3'd1) begin
          exp_we = 3'b100;
          m_w    = d[7:0];
        end else if (ph == 3'd2) begin
          exp_we = 3'b010;
          m_b    = d[15:0];
        end else begin
          exp_we = 3'b001;
          m_f    = d[7:0];
        end
        m_idx++;
      end
      if (o_weight_buffer_we) cnt_w++;
      if (o_bias_buffer_we)   cnt_b++;
      if (o_fmap_buffer_we)   cnt_f++;
      chk_eq("we", 32'({o_weight_buffer_we, o_bias_buffer_we, o_fmap_buffer_we}), 32'(exp_we));
      chk_eq("data", 32'({o_weight, o_bias_fc, o_fmap}), 32'({m_w, m_b, m_f}));
      chk_eq("phase", 32'(o_phase), 32'(phase_of(m_idx)));
      chk_eq("result_hold", 32'(o_result), 32'(m_res));
      if (v && m_idx == 1) chk_eq("slice_w", 32'(o_weight), 32'h85);
      if (v && m_idx == N_WEIGHT + 1) chk_eq("slice_b", 32'(o_bias_fc), 32'h8001);
      if (v && m_idx == N_WEIGHT + N_BIAS + 1) chk_eq("slice_f", 32'(o_fmap), 32'h7F);
      cyc++;
    end
    i_wr_valid = 1'b0;
    chk_eq("stream_reached", 32'(m_idx), 32'(stop));
  endtask

  task automatic wait_res(input int en1, input logic [3:0] r1,
                          input int en2, input logic [3:0] r2, input int end_at);
    for (int k = 0; k <= end_at; k++) begin
      i_classification_en     = (k == en1) || (k == en2);
      i_classification_result = (k == en2) ? r2 : (k == en1) ? r1 : 4'($urandom);
      i_classification_end    = (k == end_at);
      chk_eq("wait_ready", 32'(o_wr_ready), 32'd0);
      tick;
      if (k == en2)      m_res = r2;
      else if (k == en1) m_res = r1;
      i_classification_en  = 1'b0;
      i_classification_end = 1'b0;
      chk_eq("wait_result", 32'(o_result), 32'(m_res));
      if (k < end_at) begin
        chk_eq("wait_phase", 32'(o_phase), 32'd4);
        chk_eq("wait_status", 32'({o_ce, o_busy, o_done}), 32'(3'b110));
      end else begin
        chk_eq("done_phase", 32'(o_phase), 32'd5);
        chk_eq("done_status", 32'({o_ce, o_busy, o_done, o_timeout}), 32'(4'b0010));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    global_rst = 1'b1;
    user_reset = 1'b0;
    i_start = 1'b0;
    i_fmap_only = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data = '0;
    i_classification_result = '0;
    i_classification_en = 1'b0;
    i_classification_end = 1'b0;
    model_clear;
    #3;
    chk_idle_zero("reset");
    global_rst = 1'b0;
    tick;
    chk_idle_zero("post_reset");

    // abort with user_reset on bias word 5, coinciding with a transfer
    start_run(1'b0);
    stream(2, N_WEIGHT + 5);
    i_wr_valid = 1'b1;
    i_wr_data  = $urandom;
    user_reset = 1'b1;
    chk_eq("abort_ready", 32'(o_wr_ready), 32'd1);
    tick;
    user_reset = 1'b0;
    i_wr_valid = 1'b0;
    model_clear;
    chk_idle_zero("abort");
    tick;
    chk_idle_zero("abort_hold");

    // full run, back-to-back words; boundaries also prove counters restarted at 0
    start_run(1'b0);
    stream(0, TOTAL);
    chk_eq("full_n_weight", 32'(cnt_w), 32'(N_WEIGHT));
    chk_eq("full_n_bias", 32'(cnt_b), 32'(N_BIAS));
    chk_eq("full_n_fmap", 32'(cnt_f), 32'(N_FMAP));
    wait_res(2, 4'($urandom), 5, 4'd7, 8);
    chk_eq("full_result", 32'(o_result), 32'd7);

    // fmap-only from DONE, valid every other cycle, en+end in the same cycle
    start_run(1'b1);
    stream(1, TOTAL);
    chk_eq("fo_n_weight", 32'(cnt_w), 32'd0);
    chk_eq("fo_n_bias", 32'(cnt_b), 32'd0);
    chk_eq("fo_n_fmap", 32'(cnt_f), 32'(N_FMAP));
    r = 4'($urandom);
    wait_res(1, 4'($urandom), 4, r, 4);

    // timeout: core never ends
    start_run(1'b1);
    stream(2, TOTAL);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick;
      if (k < TIMEOUT) begin
        chk_eq("tmo_phase", 32'(o_phase), 32'd4);
        chk_eq("tmo_flag", 32'(o_timeout), 32'd0);
      end else begin
        chk_eq("tmo_done_phase", 32'(o_phase), 32'd5);
        chk_eq("tmo_status", 32'({o_ce, o_busy, o_done, o_timeout}), 32'(4'b0001));
      end
    end
    tick;
    tick;
    chk_eq("tmo_sticky", 32'({o_phase, o_done, o_timeout}), 32'({3'd5, 1'b0, 1'b1}));
    start_run(1'b1);

    // asynchronous global reset in the middle of fmap with a strobe in flight
    stream(0, N_WEIGHT + N_BIAS + 300);
    chk_eq("grst_pending_we", 32'(o_fmap_buffer_we), 32'd1);
    #2;
    global_rst = 1'b1;
    #1;
    model_clear;
    chk_idle_zero("grst");
    global_rst = 1'b0;
    tick;
    chk_idle_zero("grst_hold");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
